// File: rtl/kbd_spi_tx.sv
// kbd_spi_tx: SPI mode-0 transmitter for the keyboard link.
//
// Snapshots {FLAGS, KEY_MATRIX} into a 48-bit shift register when SEND is
// seen in idle, then shifts the frame out MSB first. KBD_DI changes on the
// falling edge of KBD_CLK and the receiver samples on the rising edge. After
// the last bit, KBD_CS is held low for one more half-period, then released
// for GAP_CYCLES before DONE pulses.
//
// Ports:
//   CLK_14MHZ   in   system clock, rising edge
//   RESET       in   asynchronous, active-high reset
//   SEND        in   frame request, only honoured in idle
//   KEY_MATRIX  in   [39:0] key state, 1 = released
//   FLAGS       in   [7:0] flag byte, sent first
//   BUSY        out  frame or gap in progress
//   DONE        out  one-cycle pulse at the end of the gap
//   KBD_CS      out  frame select, active low
//   KBD_CLK     out  serial clock, idle low
//   KBD_DI      out  serial data
module kbd_spi_tx #(
    parameter int unsigned CLK_DIV    = 7,   // clock cycles per SCK half-period
    parameter int unsigned GAP_CYCLES = 28   // CS-high cycles after a frame
) (
    input  logic        CLK_14MHZ,
    input  logic        RESET,
    input  logic        SEND,
    input  logic [39:0] KEY_MATRIX,
    input  logic [7:0]  FLAGS,
    output logic        BUSY,
    output logic        DONE,
    output logic        KBD_CS,
    output logic        KBD_CLK,
    output logic        KBD_DI
);

    localparam int unsigned FRAME_BITS = 48;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [5:0]       BIT_LAST = 6'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [5:0]              bit_q, bit_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    cs_q, cs_d;
    logic                    sck_q, sck_d;
    logic                    di_q, di_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    div_tick;

    assign div_tick = (div_q == DIV_LAST);

    always_ff @(posedge CLK_14MHZ or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            di_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            di_q    <= di_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        di_d    = di_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (SEND) begin
                    shreg_d = {FLAGS, KEY_MATRIX};
                    di_d    = FLAGS[7];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = StSetup;
                end
            end

            // First half-period: MSB already on KBD_DI, raise SCK at the end.
            StSetup: begin
                if (div_tick) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    state_d = StShift;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            StShift: begin
                if (div_tick) begin
                    div_d = '0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            // Last falling edge: keep bit 0 on KBD_DI for the hold phase.
                            state_d = StHold;
                        end else begin
                            shreg_d = shreg_q << 1;
                            di_d    = shreg_q[FRAME_BITS-2];
                            bit_d   = bit_q + 1'b1;
                        end
                    end else begin
                        sck_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            StHold: begin
                if (div_tick) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    di_d    = 1'b0;
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            StGap: begin
                if (gap_q == GAP_LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign KBD_CS  = cs_q;
    assign KBD_CLK = sck_q;
    assign KBD_DI  = di_q;

endmodule
